// File: rtl/neuron_pkg.sv
// neuron_pkg: default widths, FSM state type and clog2 helper
// shared by neuron_lane and neuron_mac.
package neuron_pkg;

   localparam int DEF_NUM_INPUTS   = 785;
   localparam int DEF_PIXEL_WIDTH  = 10;
   localparam int DEF_WEIGHT_WIDTH = 19;
   localparam int DEF_OUTPUT_WIDTH = 26;
   localparam int DEF_NUM_LANES    = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MAC,
      S_DRAIN,
      S_REDUCE,
      S_DONE
   } state_t;

   // Smallest r with 2**r >= value (0 for value <= 1).
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/neuron_lane.sv
// neuron_lane: one multiply-accumulate lane. Registered product of an
// unsigned pixel and a signed weight, accumulated while the product is
// valid. Ports: i_clk, i_rst (sync, high), i_clear (start of a new job),
// i_load (capture product this edge), i_pixel, i_weight, o_acc.
module neuron_lane
   import neuron_pkg::*;
#(
   parameter int PIXEL_WIDTH  = DEF_PIXEL_WIDTH,
   parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
   parameter int ACC_WIDTH    = 40
)(
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_clear,
   input  logic                        i_load,
   input  logic [PIXEL_WIDTH-1:0]      i_pixel,
   input  logic [WEIGHT_WIDTH-1:0]     i_weight,
   output logic signed [ACC_WIDTH-1:0] o_acc
);

   // Pixel gets a zero sign bit, so the product needs one extra bit.
   localparam int PROD_W = PIXEL_WIDTH + WEIGHT_WIDTH + 1;

   logic signed [PROD_W-1:0]    w_px;
   logic signed [PROD_W-1:0]    w_wt;
   logic signed [PROD_W-1:0]    w_prod;
   logic signed [PROD_W-1:0]    r_prod;
   logic                        r_pvalid;
   logic signed [ACC_WIDTH-1:0] r_acc;

   assign w_px   = PROD_W'($signed({1'b0, i_pixel}));
   assign w_wt   = PROD_W'($signed(i_weight));
   assign w_prod = w_px * w_wt;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_prod   <= '0;
         r_pvalid <= 1'b0;
         r_acc    <= '0;
      end else begin
         r_pvalid <= i_load;
         if (i_load) r_prod <= w_prod;
         if (r_pvalid) r_acc <= r_acc + ACC_WIDTH'(r_prod);
      end
   end

   assign o_acc = r_acc;

endmodule

// File: rtl/neuron_mac.sv
// neuron_mac: NUM_LANES-wide dot product of pixels and weights with a
// saturating reduction. Ports: clk, rst (sync, high), start, IN_PIXELS,
// IN_WEIGHTS, OUT, busy, done. Define NEURON_RELU_EN for ReLU on OUT.
module neuron_mac
   import neuron_pkg::*;
#(
   parameter int NUM_INPUTS   = DEF_NUM_INPUTS,
   parameter int PIXEL_WIDTH  = DEF_PIXEL_WIDTH,
   parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
   parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH,
   parameter int NUM_LANES    = DEF_NUM_LANES
)(
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 start,
   input  logic [NUM_INPUTS*PIXEL_WIDTH-1:0]    IN_PIXELS,
   input  logic [NUM_INPUTS*WEIGHT_WIDTH-1:0]   IN_WEIGHTS,
   output logic [OUTPUT_WIDTH-1:0]              OUT,
   output logic                                 busy,
   output logic                                 done
);

   localparam int NBATCH    = (NUM_INPUTS + NUM_LANES - 1) / NUM_LANES;
   localparam int BATCH_W   = (NBATCH > 1) ? clog2(NBATCH) : 1;
   localparam int ACC_WIDTH =
      PIXEL_WIDTH + WEIGHT_WIDTH + clog2(NUM_INPUTS) + 1;
   localparam int SUM_W     = ACC_WIDTH + clog2(NUM_LANES);

   state_t                      r_state;
   state_t                      w_state_nxt;
   logic [BATCH_W-1:0]          r_batch;
   logic [OUTPUT_WIDTH-1:0]     r_out;
   logic                        w_accept;
   logic                        w_load;
   logic                        w_reduce;
   logic                        w_last;
   logic signed [ACC_WIDTH-1:0] w_acc [NUM_LANES];
   logic signed [SUM_W-1:0]     w_sum;
   logic [SUM_W-OUTPUT_WIDTH:0] w_hi;
   logic [OUTPUT_WIDTH-1:0]     w_sat;
   logic [OUTPUT_WIDTH-1:0]     w_out_nxt;

   assign w_last = (r_batch == BATCH_W'(NBATCH - 1));

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_load      = 1'b0;
      w_reduce    = 1'b0;
      unique case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_accept    = 1'b1;
               w_state_nxt = S_MAC;
            end
         end
         S_MAC: begin
            w_load = 1'b1;
            if (w_last) w_state_nxt = S_DRAIN;
         end
         // Last product is still in flight; let it land.
         S_DRAIN: w_state_nxt = S_REDUCE;
         S_REDUCE: begin
            w_reduce    = 1'b1;
            w_state_nxt = S_DONE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_batch <= '0;
         r_out   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_batch <= '0;
         end else if (w_load && !w_last) begin
            r_batch <= r_batch + BATCH_W'(1);
         end
         if (w_reduce) r_out <= w_out_nxt;
      end
   end

   // Per lane, a table of its element for every batch; slots past the
   // last real element read as zero.
   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      logic [PIXEL_WIDTH-1:0]  w_pix_tab [NBATCH];
      logic [WEIGHT_WIDTH-1:0] w_wt_tab  [NBATCH];

      for (genvar b = 0; b < NBATCH; b++) begin : g_batch
         if (b * NUM_LANES + l < NUM_INPUTS) begin : g_real
            assign w_pix_tab[b] =
               IN_PIXELS[(b*NUM_LANES+l)*PIXEL_WIDTH +: PIXEL_WIDTH];
            assign w_wt_tab[b] =
               IN_WEIGHTS[(b*NUM_LANES+l)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
         end else begin : g_pad
            assign w_pix_tab[b] = '0;
            assign w_wt_tab[b]  = '0;
         end
      end

      neuron_lane #(
         .PIXEL_WIDTH  (PIXEL_WIDTH),
         .WEIGHT_WIDTH (WEIGHT_WIDTH),
         .ACC_WIDTH    (ACC_WIDTH)
      ) u_lane (
         .i_clk    (clk),
         .i_rst    (rst),
         .i_clear  (w_accept),
         .i_load   (w_load),
         .i_pixel  (w_pix_tab[r_batch]),
         .i_weight (w_wt_tab[r_batch]),
         .o_acc    (w_acc[l])
      );
   end

   always_comb begin
      w_sum = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
         w_sum = w_sum + SUM_W'(w_acc[l]);
      end
   end

   // Fits iff every bit from the output sign bit upward agrees.
   assign w_hi = w_sum[SUM_W-1:OUTPUT_WIDTH-1];

   always_comb begin
      w_sat = w_sum[OUTPUT_WIDTH-1:0];
      if (!(&w_hi) && (|w_hi)) begin
         w_sat = w_sum[SUM_W-1] ? {1'b1, {(OUTPUT_WIDTH-1){1'b0}}}
                                : {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
      end
   end

`ifdef NEURON_RELU_EN
   assign w_out_nxt = w_sat[OUTPUT_WIDTH-1] ? '0 : w_sat;
`else
   assign w_out_nxt = w_sat;
`endif

   assign OUT  = r_out;
   assign busy = (r_state == S_MAC) || (r_state == S_DRAIN) ||
                 (r_state == S_REDUCE);
   assign done = (r_state == S_DONE);

endmodule
